// File: rtl/tea_pkg.sv
// Shared constants and state encoding for the TEA datapath front end.
package tea_pkg;

    localparam int          BLOCK_BYTES    = 8;
    localparam logic [63:0] PKCS7_FULL_PAD = {BLOCK_BYTES{8'h08}};

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_PADBLK = 2'd2
    } state_e;

endpackage

// File: rtl/block_packer.sv
// Packs a byte stream into big-endian 64-bit blocks, padding the final block
// with PKCS#7 or a fixed fill byte, and hands blocks out over valid/ready.
module block_packer
    import tea_pkg::*;
#(
    parameter bit          PKCS7    = 1'b1,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [63:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_nbytes,
    output logic        m_last
);

    // Ones in every byte lane at or after position count (count = 1..8).
    function automatic logic [63:0] pad_mask(input logic [3:0] count);
        return {64{1'b1}} >> {count, 3'b000};
    endfunction

    state_e      state_q;
    logic [2:0]  idx_q;
    logic [63:0] data_q;
    logic [3:0]  nbytes_q;
    logic        last_q;
    logic        m_valid_q;
    logic        pad_pend_q;   // held block is a full final block; pad block follows

    logic        accept;
    logic        block_end;
    logic        full_last;
    logic [3:0]  count;
    logic [7:0]  pad_byte;
    logic [63:0] lane_mask;
    logic [63:0] fill_data;
    logic [63:0] pmask;
    logic [63:0] padded_data;

    assign s_ready  = (state_q == ST_FILL) && !reset;
    assign m_valid  = m_valid_q;
    assign m_data   = data_q;
    assign m_nbytes = nbytes_q;
    assign m_last   = last_q;

    assign accept    = s_valid && s_ready;
    assign block_end = s_last || (idx_q == 3'(BLOCK_BYTES - 1));
    assign full_last = PKCS7 && s_last && (idx_q == 3'(BLOCK_BYTES - 1));
    assign count     = {1'b0, idx_q} + 4'd1;
    assign pad_byte  = PKCS7 ? {4'h0, 4'(4'd8 - count)} : PAD_BYTE;

    assign lane_mask   = {8'hFF, 56'h0} >> {idx_q, 3'b000};
    assign fill_data   = (data_q & ~lane_mask) | ({s_data, 56'h0} >> {idx_q, 3'b000});
    assign pmask       = pad_mask(count);
    assign padded_data = (fill_data & ~pmask) | ({BLOCK_BYTES{pad_byte}} & pmask);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FILL;
            idx_q      <= '0;
            data_q     <= '0;
            nbytes_q   <= '0;
            last_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            pad_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        if (block_end) begin
                            data_q     <= s_last ? padded_data : fill_data;
                            nbytes_q   <= count;
                            last_q     <= s_last && !full_last;
                            pad_pend_q <= full_last;
                            m_valid_q  <= 1'b1;
                            idx_q      <= '0;
                            state_q    <= ST_HOLD;
                        end else begin
                            data_q <= fill_data;
                            idx_q  <= idx_q + 3'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        if (pad_pend_q) begin
                            data_q     <= PKCS7_FULL_PAD;
                            nbytes_q   <= '0;
                            last_q     <= 1'b1;
                            pad_pend_q <= 1'b0;
                            state_q    <= ST_PADBLK;
                        end else begin
                            nbytes_q  <= '0;
                            last_q    <= 1'b0;
                            m_valid_q <= 1'b0;
                            idx_q     <= '0;
                            state_q   <= ST_FILL;
                        end
                    end
                end
                ST_PADBLK: begin
                    if (m_ready) begin
                        nbytes_q  <= '0;
                        last_q    <= 1'b0;
                        m_valid_q <= 1'b0;
                        idx_q     <= '0;
                        state_q   <= ST_FILL;
                    end
                end
                default: begin
                    m_valid_q <= 1'b0;
                    state_q   <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_packer.sv
// Directed bench: packer 0 uses fixed fill byte A5, packer 1 uses PKCS#7.
module tb_block_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_last;
    logic [1:0]  s_valid;
    logic [1:0]  s_ready;
    logic [1:0]  m_ready;
    logic [63:0] m_data   [2];
    logic [1:0]  m_valid;
    logic [3:0]  m_nbytes [2];
    logic [1:0]  m_last;

    int errors = 0;
    int checks = 0;

    block_packer #(.PKCS7(1'b0), .PAD_BYTE(8'hA5)) u_pk0 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid[0]),
        .s_last(s_last), .s_ready(s_ready[0]), .m_data(m_data[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_nbytes(m_nbytes[0]),
        .m_last(m_last[0])
    );

    block_packer #(.PKCS7(1'b1)) u_pk1 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid[1]),
        .s_last(s_last), .s_ready(s_ready[1]), .m_data(m_data[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_nbytes(m_nbytes[1]),
        .m_last(m_last[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end on a falling edge.
    task automatic push(input int sel, input logic [7:0] d, input logic l);
        s_data = d;
        s_last = l;
        s_valid[sel] = 1'b1;
        @(negedge clk);
        s_valid[sel] = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic take(input int sel);
        m_ready[sel] = 1'b1;
        @(negedge clk);
        m_ready[sel] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_valid = 2'b11;
        m_ready = 2'b11;
        s_data = 8'h5A;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_valid, m_last, s_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {m_valid, m_last, s_ready});
        end
        checks++;
        if ({m_nbytes[0], m_nbytes[1], m_data[0], m_data[1]} !== 136'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {m_nbytes[0], m_nbytes[1], m_data[0], m_data[1]});
        end
        s_valid = 2'b00;
        m_ready = 2'b00;
        reset = 1'b0;
        #1;
        checks++;
        if (s_ready !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 11", s_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_full_block();
        for (int i = 1; i <= 7; i++) push(0, 8'(i), 1'b0);
        checks++;
        if (m_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_early_valid: got %b want 0", m_valid[0]);
        end
        push(0, 8'h08, 1'b1);
        checks++;
        if ({m_valid[0], m_last[0], m_nbytes[0], m_data[0]} !== {1'b1, 1'b1, 4'd8, 64'h0102030405060708}) begin
            errors++;
            $display("FAIL full_block: got %b %b %0d %h want 1 1 8 0102030405060708",
                     m_valid[0], m_last[0], m_nbytes[0], m_data[0]);
        end
        take(0);
        checks++;
        if ({m_valid[0], s_ready[0]} !== 2'b01) begin
            errors++;
            $display("FAIL full_after_take: got %b want 01", {m_valid[0], s_ready[0]});
        end
    endtask

    task automatic test_fill_byte();
        push(0, 8'h12, 1'b0);
        push(0, 8'h34, 1'b1);
        checks++;
        if ({m_valid[0], m_last[0], m_nbytes[0], m_data[0]} !== {1'b1, 1'b1, 4'd2, 64'h1234A5A5A5A5A5A5}) begin
            errors++;
            $display("FAIL fill_byte: got %b %b %0d %h want 1 1 2 1234a5a5a5a5a5a5",
                     m_valid[0], m_last[0], m_nbytes[0], m_data[0]);
        end
        take(0);
    endtask

    task automatic test_pkcs7_partial();
        push(1, 8'hAA, 1'b0);
        push(1, 8'hBB, 1'b0);
        push(1, 8'hCC, 1'b1);
        checks++;
        if ({m_valid[1], m_last[1], m_nbytes[1], m_data[1]} !== {1'b1, 1'b1, 4'd3, 64'hAABBCC0505050505}) begin
            errors++;
            $display("FAIL pkcs7_partial: got %b %b %0d %h want 1 1 3 aabbcc0505050505",
                     m_valid[1], m_last[1], m_nbytes[1], m_data[1]);
        end
        take(1);
    endtask

    task automatic test_pkcs7_full();
        for (int i = 1; i <= 8; i++) push(1, 8'(i * 8'h11), i == 8);
        checks++;
        if ({m_valid[1], m_last[1], m_nbytes[1], m_data[1]} !== {1'b1, 1'b0, 4'd8, 64'h1122334455667788}) begin
            errors++;
            $display("FAIL pkcs7_full_blk1: got %b %b %0d %h want 1 0 8 1122334455667788",
                     m_valid[1], m_last[1], m_nbytes[1], m_data[1]);
        end
        take(1);
        checks++;
        if ({s_ready[1], m_valid[1], m_last[1], m_nbytes[1], m_data[1]} !== {1'b0, 1'b1, 1'b1, 4'd0, 64'h0808080808080808}) begin
            errors++;
            $display("FAIL pkcs7_padblk: got rdy=%b %b %b %0d %h want 0 1 1 0 0808080808080808",
                     s_ready[1], m_valid[1], m_last[1], m_nbytes[1], m_data[1]);
        end
        take(1);
        checks++;
        if ({m_valid[1], s_ready[1]} !== 2'b01) begin
            errors++;
            $display("FAIL pkcs7_padblk_exit: got %b want 01", {m_valid[1], s_ready[1]});
        end
    endtask

    task automatic test_backpressure();
        for (int i = 1; i <= 8; i++) push(1, 8'(i), 1'b0);
        s_data = 8'h99;
        s_last = 1'b1;
        s_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({s_ready[1], m_valid[1], m_last[1], m_nbytes[1], m_data[1]} !== {1'b0, 1'b1, 1'b0, 4'd8, 64'h0102030405060708}) begin
                errors++;
                $display("FAIL backpressure_hold c=%0d: got rdy=%b %b %b %0d %h want 0 1 0 8 0102030405060708",
                         c, s_ready[1], m_valid[1], m_last[1], m_nbytes[1], m_data[1]);
            end
        end
        s_valid[1] = 1'b0;
        s_last = 1'b0;
        take(1);
        push(1, 8'h9A, 1'b1);
        checks++;
        if ({m_valid[1], m_last[1], m_nbytes[1], m_data[1]} !== {1'b1, 1'b1, 4'd1, 64'h9A07070707070707}) begin
            errors++;
            $display("FAIL backpressure_next: got %b %b %0d %h want 1 1 1 9a07070707070707",
                     m_valid[1], m_last[1], m_nbytes[1], m_data[1]);
        end
        take(1);
    endtask

    task automatic test_reset_mid_fill();
        for (int i = 1; i <= 4; i++) push(0, 8'(8'hF0 + i), 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({m_valid[0], m_data[0]} !== 65'h0) begin
            errors++;
            $display("FAIL reset_mid_state: got %b %h want 0 0", m_valid[0], m_data[0]);
        end
        for (int i = 1; i <= 8; i++) push(0, 8'(8'h20 + i), i == 8);
        checks++;
        if ({m_valid[0], m_last[0], m_nbytes[0], m_data[0]} !== {1'b1, 1'b1, 4'd8, 64'h2122232425262728}) begin
            errors++;
            $display("FAIL reset_mid_block: got %b %b %0d %h want 1 1 8 2122232425262728",
                     m_valid[0], m_last[0], m_nbytes[0], m_data[0]);
        end
        take(0);
    endtask

    task automatic test_two_block();
        for (int i = 1; i <= 8; i++) push(1, 8'(i), 1'b0);
        checks++;
        if ({m_valid[1], m_last[1], m_nbytes[1], m_data[1]} !== {1'b1, 1'b0, 4'd8, 64'h0102030405060708}) begin
            errors++;
            $display("FAIL two_block_1: got %b %b %0d %h want 1 0 8 0102030405060708",
                     m_valid[1], m_last[1], m_nbytes[1], m_data[1]);
        end
        take(1);
        for (int i = 9; i <= 12; i++) push(1, 8'(i), i == 12);
        checks++;
        if ({m_valid[1], m_last[1], m_nbytes[1], m_data[1]} !== {1'b1, 1'b1, 4'd4, 64'h090A0B0C04040404}) begin
            errors++;
            $display("FAIL two_block_2: got %b %b %0d %h want 1 1 4 090a0b0c04040404",
                     m_valid[1], m_last[1], m_nbytes[1], m_data[1]);
        end
        take(1);
    endtask

    task automatic test_back_to_back();
        int nbytes_in;
        int nblocks;
        nbytes_in = 0;
        nblocks = 0;
        s_valid[0] = 1'b1;
        m_ready[0] = 1'b1;
        s_last = 1'b0;
        for (int c = 0; c < 27; c++) begin
            s_data = 8'(c);
            if (s_ready[0] === 1'b1) nbytes_in++;
            if (m_valid[0] === 1'b1) nblocks++;
            @(negedge clk);
        end
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b0;
        checks++;
        if (nbytes_in != 24 || nblocks != 3) begin
            errors++;
            $display("FAIL back_to_back: got bytes=%0d blocks=%0d want 24 3", nbytes_in, nblocks);
        end
    endtask

    initial begin
        reset = 1'b1;
        s_data = 8'h00;
        s_last = 1'b0;
        s_valid = 2'b00;
        m_ready = 2'b00;
        @(negedge clk);
        test_reset();
        test_full_block();
        test_fill_byte();
        test_pkcs7_partial();
        test_pkcs7_full();
        test_backpressure();
        test_reset_mid_fill();
        test_two_block();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
